// File: rtl/control_circuit_gen2.sv
// rtl/control_circuit_gen2.sv - instruction sequencer for the register-file/ALU datapath
module control_circuit_gen2 #(
  parameter  int NUM_REG    = 16,
  parameter  int CNT_W      = 16,
  localparam int REG_ADDR_W = $clog2(NUM_REG),
  localparam int IW         = 3 + 2 * REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [IW-1:0]         INSTRUCTION,
  input  logic                  Run,
  output logic                  Ready,
  output logic [NUM_REG-1:0]    Rin,
  output logic [NUM_REG-1:0]    Rout,
  output logic                  External_load,
  output logic [REG_ADDR_W-1:0] IMM,
  output logic                  ALU_a_in,
  output logic                  ALU_g_in,
  output logic                  ALU_g_out,
  output logic [2:0]            ALU_mode,
  output logic                  Done,
  output logic                  Error,
  output logic [CNT_W-1:0]      INSTR_COUNT
);

  typedef enum logic [1:0] {S_IDLE, S_T1, S_T2, S_T3} state_t;

  localparam logic [NUM_REG-1:0] ONE_HOT_0 = NUM_REG'(1);

  state_t                  state_q;
  logic [IW-1:0]           instr_q;
  logic [CNT_W-1:0]        cnt_q;

  logic [2:0]              op;
  logic [REG_ADDR_W-1:0]   rx;
  logic [REG_ADDR_W-1:0]   ry;
  logic                    is_alu;
  logic                    is_ill;
  logic                    done_w;
  logic                    ready_w;

  assign op     = instr_q[IW-1 -: 3];
  assign rx     = instr_q[2*REG_ADDR_W-1 -: REG_ADDR_W];
  assign ry     = instr_q[REG_ADDR_W-1:0];
  assign is_alu = (op >= 3'd2) && (op <= 3'd6);
  assign is_ill = (op == 3'd7);
  assign done_w = ((state_q == S_T1) && !is_alu) || (state_q == S_T3);
  assign ready_w = (state_q == S_IDLE) || done_w;

  // A Done cycle doubles as an accept slot, so back-to-back issue needs no IDLE gap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      instr_q <= '0;
      cnt_q   <= '0;
    end else begin
      if (done_w) cnt_q <= cnt_q + 1'b1;
      if (Run && ready_w) begin
        instr_q <= INSTRUCTION;
        state_q <= S_T1;
      end else begin
        case (state_q)
          S_T1:    state_q <= is_alu ? S_T2 : S_IDLE;
          S_T2:    state_q <= S_T3;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    Rin           = '0;
    Rout          = '0;
    External_load = 1'b0;
    IMM           = '0;
    ALU_a_in      = 1'b0;
    ALU_g_in      = 1'b0;
    ALU_g_out     = 1'b0;
    ALU_mode      = 3'b000;
    Error         = 1'b0;
    if (is_alu && (state_q != S_IDLE)) ALU_mode = op - 3'd2;
    case (state_q)
      S_T1: begin
        if (op == 3'd0) begin
          Rin           = ONE_HOT_0 << rx;
          External_load = 1'b1;
          IMM           = ry;
        end else if (op == 3'd1) begin
          Rout = ONE_HOT_0 << ry;
          Rin  = ONE_HOT_0 << rx;
        end else if (is_alu) begin
          Rout     = ONE_HOT_0 << rx;
          ALU_a_in = 1'b1;
        end else begin
          Error = is_ill;
        end
      end
      S_T2: begin
        Rout     = ONE_HOT_0 << ry;
        ALU_g_in = 1'b1;
      end
      S_T3: begin
        ALU_g_out = 1'b1;
        Rin       = ONE_HOT_0 << rx;
      end
      default: ;
    endcase
  end

  assign Done        = done_w;
  assign Ready       = ready_w;
  assign INSTR_COUNT = cnt_q;

endmodule
